qcore_ctrl_pipe: RTL and testbench
==================================

Name: qcore_ctrl_pipe

Overview:
Pipeline sequencer for the qcore six-stage pipe (IF, ID, RD, X1, X2, WR). It consumes the bubble requests, halt and jump flush produced by the hazard/branch logic, and drives per-stage register enables and per-stage valid bits. Downstream write enables (reg we, r_wave_we, flag_we, wmem_we) are ANDed with the stage valid bits by their owners. It also measures stall length and flags runaway stalls.

Parameters:
CNT_W, 8, width of consecutive-stall counter
MAX_STALL, 200, consecutive stall cycles that trigger stall_timeout_o (must be < 2^CNT_W)

Ports:
clk_i  in  1  core clock
rst_ni  in  1  reset, asynchronous, active-low
halt_i  in  1  freeze entire pipe; no state changes
fetch_vld_i  in  1  instruction memory returns a valid word this cycle
bubble_id_i  in  1  hold ID, insert bubble into RD
bubble_rd_i  in  1  hold RD, insert bubble into X1
flush_i  in  1  jump/branch taken, resolved in X1; kill IF/ID/RD
clr_i  in  1  clear stall_timeout_o and stall counter
pc_en_o  out  1  PC register update enable
if_en_o  out  1  IF/ID register enable
id_en_o  out  1  ID/RD register enable
rd_en_o  out  1  RD/X1 register enable
x_en_o  out  1  X1/X2/WR register enable
vld_o  out  6  stage valid, [0]=IF … [5]=WR
stall_cnt_o  out  CNT_W  current consecutive-stall count
stall_timeout_o  out  1  sticky runaway-stall flag
stat_bid_o  out  32  total bubble_id cycles (optional feature)
stat_brd_o  out  32  total bubble_rd cycles (optional feature)

Behaviour:
- Reset: vld_o=0, stall_cnt_o=0, stall_timeout_o=0, stats=0. A run flag is set on the first clk_i edge after rst_ni rises. All *_en_o are 0 while rst_ni is low or the run flag is 0, so there is 1 cycle of start latency.
- Enables are combinational from the current inputs. vld_o, the counters and the flag are registered.
- Priority, highest first: halt_i, flush_i, bubble_rd_i, bubble_id_i, normal.
- HALT: all *_en_o=0. vld_o, counters and stats hold. Other inputs are ignored.
- FLUSH: pc_en, if_en, id_en, rd_en, x_en all 1. Next state vld[0]=fetch_vld_i, vld[1..3]=0, vld[4]=vld[3], vld[5]=vld[4]. Concurrent bubbles are discarded because their requesters are killed. The stall counter is not incremented.
- BUBBLE_RD: pc_en=if_en=id_en=rd_en=0, x_en=1. Next state vld[0..2] hold, vld[3]=0, vld[4]=vld[3], vld[5]=vld[4].
- BUBBLE_ID (bubble_rd_i low): pc_en=if_en=id_en=0, rd_en=x_en=1. Next state vld[0..1] hold, vld[2]=0, vld[3]=vld[2], vld[4]=vld[3], vld[5]=vld[4].
- NORMAL: all enables 1. Next state vld[0]=fetch_vld_i, vld[i]=vld[i-1].
- Stall counter:
  - +1 on each non-halted cycle with bubble_id_i|bubble_rd_i and no flush_i.
  - Resets to 0 on a non-halted cycle with no bubble, or on clr_i.
  - Saturates at 2^CNT_W-1.
- Timeout: stall_timeout_o is set registered in the cycle the counter's next value equals MAX_STALL. It stays sticky until clr_i or reset. Setting it does not alter pipe behaviour.
- clr_i is honoured even during halt_i. clr_i wins over a same-cycle increment, so the counter goes to 0.
- Reset mid-stall: everything returns to reset values asynchronously, and in-flight valids are lost.

Optional Feature:
- Macro QCORE_PIPE_STATS_EN.
- Defined: stat_bid_o counts non-halted, non-flush cycles with bubble_id_i=1 and bubble_rd_i=0. stat_brd_o counts non-halted, non-flush cycles with bubble_rd_i=1. Both are 32-bit and wrap modulo 2^32, and both are cleared by reset only.
- Not defined: stat_bid_o and stat_brd_o are tied to 0, with no counter logic.

Test Plan:
- Reset release, fetch_vld_i=1 constant -> enables 0 in the first cycle. vld_o then fills 000001, 000011 … 111111 over cycles 2-7.
- Full pipe, bubble_rd_i high 2 cycles -> pc/if/id/rd_en=0 and x_en=1 for 2 cycles. vld[3]=0 after cycle 1, stall_cnt_o=1 then 2, then back to 0.
- Full pipe, bubble_id_i and bubble_rd_i both high 1 cycle -> bubble_rd behaviour applies: rd_en=0, vld[3]=0 next, vld[2] unchanged.
- Full pipe, flush_i with bubble_id_i in the same cycle, fetch_vld_i=1 -> all enables 1. Next vld_o=110001 and stall_cnt_o stays 0.
- halt_i high 3 cycles during bubble_rd_i -> all enables 0. vld_o and stall_cnt_o are frozen, then resume counting after halt drops.
- MAX_STALL=5, bubble_id_i held 6 cycles -> stall_timeout_o rises when stall_cnt_o=5 and stays high. clr_i pulse -> flag and counter read 0 the next cycle. With QCORE_PIPE_STATS_EN, stat_bid_o=6.

Source files
------------

// File: rtl/qcore_ctrl_pipe.sv
// Sequencer for the qcore six-stage pipe: stage enables, valid bits, stall monitor.
// Optional per-bubble statistics are built when QCORE_PIPE_STATS_EN is defined.
module qcore_ctrl_pipe #(
  parameter int CNT_W     = 8,
  parameter int MAX_STALL = 200
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             halt_i,
  input  logic             fetch_vld_i,
  input  logic             bubble_id_i,
  input  logic             bubble_rd_i,
  input  logic             flush_i,
  input  logic             clr_i,
  output logic             pc_en_o,
  output logic             if_en_o,
  output logic             id_en_o,
  output logic             rd_en_o,
  output logic             x_en_o,
  output logic [5:0]       vld_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             stall_timeout_o,
  output logic [31:0]      stat_bid_o,
  output logic [31:0]      stat_brd_o
);

  typedef enum logic [2:0] {
    M_IDLE,
    M_HALT,
    M_FLUSH,
    M_BRD,
    M_BID,
    M_NORM
  } mode_e;

  mode_e            w_mode;
  logic             r_run;
  logic [5:0]       r_vld;
  logic [5:0]       w_vld_nxt;
  logic [4:0]       w_en;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             r_to;
  logic             w_stall;

  // Mode decode in priority order; idle covers reset and the start-latency cycle.
  always_comb begin
    w_mode = M_NORM;
    if (!rst_ni || !r_run) w_mode = M_IDLE;
    else if (halt_i)       w_mode = M_HALT;
    else if (flush_i)      w_mode = M_FLUSH;
    else if (bubble_rd_i)  w_mode = M_BRD;
    else if (bubble_id_i)  w_mode = M_BID;
  end

  always_comb begin
    w_en      = '0;
    w_vld_nxt = r_vld;
    unique case (w_mode)
      M_FLUSH: begin
        w_en      = '1;
        w_vld_nxt = {r_vld[4:3], 3'b000, fetch_vld_i};
      end
      M_BRD: begin
        w_en      = 5'b00001;
        w_vld_nxt = {r_vld[4:3], 1'b0, r_vld[2:0]};
      end
      M_BID: begin
        w_en      = 5'b00011;
        w_vld_nxt = {r_vld[4:2], 1'b0, r_vld[1:0]};
      end
      M_NORM: begin
        w_en      = '1;
        w_vld_nxt = {r_vld[4:0], fetch_vld_i};
      end
      default: ;
    endcase
  end

  assign w_stall   = (w_mode == M_BRD) || (w_mode == M_BID);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

  // A flush ends any stall run, so it clears the counter like a normal cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_run <= 1'b0;
      r_vld <= '0;
      r_cnt <= '0;
      r_to  <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_vld <= w_vld_nxt;
      if (clr_i) begin
        r_cnt <= '0;
        r_to  <= 1'b0;
      end else if (w_stall) begin
        r_cnt <= w_cnt_inc;
        if (w_cnt_inc == CNT_W'(MAX_STALL)) r_to <= 1'b1;
      end else if (w_mode == M_FLUSH || w_mode == M_NORM) begin
        r_cnt <= '0;
      end
    end
  end

`ifdef QCORE_PIPE_STATS_EN
  logic [31:0] r_stat_bid;
  logic [31:0] r_stat_brd;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stat_bid <= '0;
      r_stat_brd <= '0;
    end else begin
      if (w_mode == M_BID) r_stat_bid <= r_stat_bid + 32'd1;
      if (w_mode == M_BRD) r_stat_brd <= r_stat_brd + 32'd1;
    end
  end

  assign stat_bid_o = r_stat_bid;
  assign stat_brd_o = r_stat_brd;
`else
  assign stat_bid_o = '0;
  assign stat_brd_o = '0;
`endif

  assign pc_en_o         = w_en[4];
  assign if_en_o         = w_en[3];
  assign id_en_o         = w_en[2];
  assign rd_en_o         = w_en[1];
  assign x_en_o          = w_en[0];
  assign vld_o           = r_vld;
  assign stall_cnt_o     = r_cnt;
  assign stall_timeout_o = r_to;

endmodule

// File: tb/tb_qcore_ctrl_pipe.sv
// Self-checking bench for qcore_ctrl_pipe (MAX_STALL overridden to 5).
module tb_qcore_ctrl_pipe;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        halt_i = 1'b0, fetch_vld_i = 1'b0, bubble_id_i = 1'b0;
  logic        bubble_rd_i = 1'b0, flush_i = 1'b0, clr_i = 1'b0;
  logic        pc_en_o, if_en_o, id_en_o, rd_en_o, x_en_o;
  logic [5:0]  vld_o;
  logic [7:0]  stall_cnt_o;
  logic        stall_timeout_o;
  logic [31:0] stat_bid_o, stat_brd_o;

  qcore_ctrl_pipe #(.CNT_W(8), .MAX_STALL(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .halt_i(halt_i), .fetch_vld_i(fetch_vld_i),
    .bubble_id_i(bubble_id_i), .bubble_rd_i(bubble_rd_i), .flush_i(flush_i),
    .clr_i(clr_i), .pc_en_o(pc_en_o), .if_en_o(if_en_o), .id_en_o(id_en_o),
    .rd_en_o(rd_en_o), .x_en_o(x_en_o), .vld_o(vld_o), .stall_cnt_o(stall_cnt_o),
    .stall_timeout_o(stall_timeout_o), .stat_bid_o(stat_bid_o), .stat_brd_o(stat_brd_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic h, f, bid, brd, fl, clr;
    logic [4:0] en;
    logic [5:0] vld;
    logic [7:0] cnt;
    logic to;
  } vec_t;

  typedef struct {
    int idx;
    logic [5:0] vld;
    logic [7:0] cnt;
    logic to;
  } exp_t;

  vec_t tbl[42];
  exp_t sb[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(input logic h, f, bid, brd, fl, clr,
                              input logic [4:0] en, input logic [5:0] vld,
                              input logic [7:0] cnt, input logic to);
    vec_t t;
    t.h = h; t.f = f; t.bid = bid; t.brd = brd; t.fl = fl; t.clr = clr;
    t.en = en; t.vld = vld; t.cnt = cnt; t.to = to;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0h want=%0h", name, idx, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    exp_t e;
    @(negedge clk_i);
    halt_i = t.h; fetch_vld_i = t.f; bubble_id_i = t.bid;
    bubble_rd_i = t.brd; flush_i = t.fl; clr_i = t.clr;
    e.idx = idx; e.vld = t.vld; e.cnt = t.cnt; e.to = t.to;
    sb.push_back(e);
    #2;
    chk("en", idx, {27'd0, pc_en_o, if_en_o, id_en_o, rd_en_o, x_en_o}, {27'd0, t.en});
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    chk("vld", e.idx, {26'd0, vld_o}, {26'd0, e.vld});
    chk("cnt", e.idx, {24'd0, stall_cnt_o}, {24'd0, e.cnt});
    chk("to", e.idx, {31'd0, stall_timeout_o}, {31'd0, e.to});
  endtask

  initial begin
    //                h  f bid brd fl clr  en        vld        cnt to
    tbl[0]  = mk(0, 1, 0, 0, 0, 0, 5'b00000, 6'b000000, 0, 0);
    tbl[1]  = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b000001, 0, 0);
    tbl[2]  = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b000011, 0, 0);
    tbl[3]  = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b000111, 0, 0);
    tbl[4]  = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b001111, 0, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b011111, 0, 0);
    tbl[6]  = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b111111, 0, 0);
    tbl[7]  = mk(0, 1, 0, 1, 0, 0, 5'b00001, 6'b110111, 1, 0);
    tbl[8]  = mk(0, 1, 0, 1, 0, 0, 5'b00001, 6'b100111, 2, 0);
    tbl[9]  = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b001111, 0, 0);
    tbl[10] = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b011111, 0, 0);
    tbl[11] = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b111111, 0, 0);
    tbl[12] = mk(0, 1, 1, 1, 0, 0, 5'b00001, 6'b110111, 1, 0);
    tbl[13] = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b101111, 0, 0);
    tbl[14] = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b011111, 0, 0);
    tbl[15] = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b111111, 0, 0);
    tbl[16] = mk(0, 1, 1, 0, 1, 0, 5'b11111, 6'b110001, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 5'b11111, 6'b100010, 0, 0);
    tbl[18] = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b000101, 0, 0);
    tbl[19] = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b001011, 0, 0);
    tbl[20] = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b010111, 0, 0);
    tbl[21] = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b101111, 0, 0);
    tbl[22] = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b011111, 0, 0);
    tbl[23] = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b111111, 0, 0);
    tbl[24] = mk(0, 1, 0, 1, 0, 0, 5'b00001, 6'b110111, 1, 0);
    tbl[25] = mk(1, 1, 0, 1, 0, 0, 5'b00000, 6'b110111, 1, 0);
    tbl[26] = mk(1, 1, 0, 1, 0, 0, 5'b00000, 6'b110111, 1, 0);
    tbl[27] = mk(1, 1, 0, 1, 0, 0, 5'b00000, 6'b110111, 1, 0);
    tbl[28] = mk(0, 1, 0, 1, 0, 0, 5'b00001, 6'b100111, 2, 0);
    tbl[29] = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b001111, 0, 0);
    tbl[30] = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b011111, 0, 0);
    tbl[31] = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b111111, 0, 0);
    tbl[32] = mk(0, 1, 1, 0, 0, 0, 5'b00011, 6'b111011, 1, 0);
    tbl[33] = mk(0, 1, 1, 0, 0, 0, 5'b00011, 6'b110011, 2, 0);
    tbl[34] = mk(0, 1, 1, 0, 0, 0, 5'b00011, 6'b100011, 3, 0);
    tbl[35] = mk(0, 1, 1, 0, 0, 0, 5'b00011, 6'b000011, 4, 0);
    tbl[36] = mk(0, 1, 1, 0, 0, 0, 5'b00011, 6'b000011, 5, 1);
    tbl[37] = mk(0, 1, 1, 0, 0, 0, 5'b00011, 6'b000011, 6, 1);
    tbl[38] = mk(1, 1, 1, 0, 0, 1, 5'b00000, 6'b000011, 0, 0);
    tbl[39] = mk(0, 1, 1, 0, 0, 0, 5'b00011, 6'b000011, 1, 0);
    tbl[40] = mk(0, 1, 1, 0, 0, 1, 5'b00011, 6'b000011, 0, 0);
    tbl[41] = mk(0, 1, 0, 0, 0, 0, 5'b11111, 6'b000111, 0, 0);

    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_vld", 0, {26'd0, vld_o}, 32'd0);
    chk("rst_en", 0, {27'd0, pc_en_o, if_en_o, id_en_o, rd_en_o, x_en_o}, 32'd0);
    chk("rst_stat", 0, stat_bid_o | stat_brd_o, 32'd0);
    #2 rst_ni = 1'b1;

    for (int unsigned i = 0; i < 42; i++) run_vec(tbl[i], int'(i));

`ifdef QCORE_PIPE_STATS_EN
    chk("stat_bid", 0, stat_bid_o, 32'd8);
    chk("stat_brd", 0, stat_brd_o, 32'd5);
`else
    chk("stat_bid", 0, stat_bid_o, 32'd0);
    chk("stat_brd", 0, stat_brd_o, 32'd0);
`endif

    // Long stall: counter must saturate at 255 with the flag held.
    @(negedge clk_i);
    bubble_id_i = 1'b1; clr_i = 1'b0; halt_i = 1'b0; flush_i = 1'b0; bubble_rd_i = 1'b0;
    repeat (260) @(posedge clk_i);
    #1;
    chk("sat_cnt", 0, {24'd0, stall_cnt_o}, 32'd255);
    chk("sat_to", 0, {31'd0, stall_timeout_o}, 32'd1);
    chk("sat_en", 0, {27'd0, pc_en_o, if_en_o, id_en_o, rd_en_o, x_en_o}, 32'd3);

    // Asynchronous reset in the middle of the stall.
    #2 rst_ni = 1'b0;
    #1;
    chk("arst_en", 0, {27'd0, pc_en_o, if_en_o, id_en_o, rd_en_o, x_en_o}, 32'd0);
    chk("arst_vld", 0, {26'd0, vld_o}, 32'd0);
    chk("arst_cnt", 0, {24'd0, stall_cnt_o}, 32'd0);
    chk("arst_to", 0, {31'd0, stall_timeout_o}, 32'd0);
    chk("arst_stat", 0, stat_bid_o | stat_brd_o, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
